// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner: multiplexes four hex digits onto a common-anode 7-segment display, tear-free per frame.
// Optional macro SEVEN_SEG_LEADING_ZERO_BLANK_EN blanks a zero value in slots 1 and 3.
module seven_seg_scanner #(
    parameter int SLOT_CYCLES  = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       digit0_en_i,
    input  logic       digit1_en_i,
    input  logic       digit2_en_i,
    input  logic       digit3_en_i,
    input  logic [3:0] digit0_i,
    input  logic [3:0] digit1_i,
    input  logic [3:0] digit2_i,
    input  logic [3:0] digit3_i,
    output logic [3:0] anode_o,
    output logic [6:0] segments_o,
    output logic       dp_o
);
    localparam int PW = $clog2(SLOT_CYCLES);
    typedef enum logic {BLANK, SHOW} state_t;
    logic [19:0] w_in, r_sync1, r_sync2, r_snap;
    logic [PW-1:0] r_pre, w_pre_next;
    logic [1:0] r_idx;
    logic w_wrap, w_en, w_lit;
    logic [3:0] w_val, w_ens;
    logic [6:0] w_seg;
    state_t r_state, w_state_next;
    assign w_in = {digit3_en_i, digit2_en_i, digit1_en_i, digit0_en_i, digit3_i, digit2_i, digit1_i, digit0_i};
    assign w_wrap = r_pre == PW'(SLOT_CYCLES - 1);
    assign w_ens = r_snap[19:16];
    assign w_en = w_ens[r_idx];
    assign w_val = r_snap[{r_idx, 2'b00} +: 4];
    assign dp_o = 1'b1;
    always_comb begin
        w_pre_next = w_wrap ? '0 : r_pre + PW'(1);
        w_state_next = (w_pre_next < PW'(BLANK_CYCLES)) ? BLANK : SHOW;
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
        w_lit = (r_state == SHOW) && w_en && !(r_idx[0] && w_val == 4'h0);
`else
        w_lit = (r_state == SHOW) && w_en;
`endif
    end
    always_comb begin
        w_seg = 7'h7F;
        case (w_val)
            4'h0: w_seg = 7'b1000000;
            4'h1: w_seg = 7'b1111001;
            4'h2: w_seg = 7'b0100100;
            4'h3: w_seg = 7'b0110000;
            4'h4: w_seg = 7'b0011001;
            4'h5: w_seg = 7'b0010010;
            4'h6: w_seg = 7'b0000010;
            4'h7: w_seg = 7'b1111000;
            4'h8: w_seg = 7'b0000000;
            4'h9: w_seg = 7'b0010000;
            4'hA: w_seg = 7'b0001000;
            4'hB: w_seg = 7'b0000011;
            4'hC: w_seg = 7'b1000110;
            4'hD: w_seg = 7'b0100001;
            4'hE: w_seg = 7'b0000110;
            default: w_seg = 7'b0001110;
        endcase
    end
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_snap <= '0;
            r_pre <= '0;
            r_idx <= '0;
            r_state <= BLANK;
            anode_o <= 4'hF;
            segments_o <= 7'h7F;
        end else begin
            r_sync1 <= w_in;
            r_sync2 <= r_sync1;
            if (w_wrap && r_idx == 2'd3) r_snap <= r_sync2;
            r_pre <= w_pre_next;
            if (w_wrap) r_idx <= r_idx + 2'd1;
            r_state <= w_state_next;
            anode_o <= w_lit ? ~(4'b0001 << r_idx) : 4'hF;
            segments_o <= w_lit ? w_seg : 7'h7F;
        end
    end
endmodule

// File: tb/tb_seven_seg_scanner.sv
// tb_seven_seg_scanner: directed and random stimulus checked every cycle against a frame-level display model.
module tb_seven_seg_scanner;
    localparam int S = 8;
    localparam int B = 2;
    localparam int F = 4 * S;
    logic clk = 1'b0;
    logic rst_n;
    logic [3:0] en;
    logic [3:0] dv [4];
    logic [3:0] anode_o;
    logic [6:0] segments_o;
    logic dp_o;
    logic [6:0] seg_tab [16];
    logic [19:0] hist [8192];
    logic [19:0] snap_m;
    int n = 0;
    int tests = 0;
    int fails = 0;

    seven_seg_scanner #(.SLOT_CYCLES(S), .BLANK_CYCLES(B)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .digit0_en_i(en[0]), .digit1_en_i(en[1]), .digit2_en_i(en[2]), .digit3_en_i(en[3]),
        .digit0_i(dv[0]), .digit1_i(dv[1]), .digit2_i(dv[2]), .digit3_i(dv[3]),
        .anode_o(anode_o), .segments_o(segments_o), .dp_o(dp_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        logic [3:0] exp_an;
        logic [6:0] exp_seg;
        logic [3:0] v;
        logic lit;
        int c, slot;
        @(posedge clk);
        exp_an = 4'hF;
        exp_seg = 7'h7F;
        if (!rst_n) begin
            n = 0;
            snap_m = '0;
        end else begin
            n++;
            hist[n % 8192] = {en, dv[3], dv[2], dv[1], dv[0]};
            c = n - 1;
            slot = (c / S) % 4;
            v = snap_m[slot*4 +: 4];
            lit = (c % S >= B) && snap_m[16 + slot];
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
            if (slot % 2 == 1 && v == 4'h0) lit = 1'b0;
`endif
            if (lit) begin
                exp_an[slot] = 1'b0;
                exp_seg = seg_tab[v];
            end
        end
        #1;
        tests++;
        assert (anode_o === exp_an) else begin
            fails++;
            $error("FAIL anode n=%0d got %b exp %b", n, anode_o, exp_an);
        end
        tests++;
        assert (segments_o === exp_seg) else begin
            fails++;
            $error("FAIL segments n=%0d got %b exp %b", n, segments_o, exp_seg);
        end
        tests++;
        assert (dp_o === 1'b1 && $countones(~anode_o) <= 1) else begin
            fails++;
            $error("FAIL dp_onehot n=%0d got dp=%b anode=%b exp dp=1 at most one low", n, dp_o, anode_o);
        end
        if (rst_n && n % F == 0) snap_m = hist[(n - 2) % 8192];
    endtask

    task automatic run(input int k);
        for (int i = 0; i < k; i++) tick();
    endtask

    task automatic run_to(input int phase);
        for (int i = 0; i < F && n % F != phase; i++) tick();
    endtask

    initial begin
        seg_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
        snap_m = '0;
        rst_n = 1'b0;
        en = 4'hF;
        dv[0] = 4'h5; dv[1] = 4'h1; dv[2] = 4'hA; dv[3] = 4'h0;
        run(3);
        rst_n = 1'b1;
        run(F);
        run(2 * F);
        en[2] = 1'b0;
        run(2 * F);
        en = 4'hF;
        run_to(0);
        run_to(S + 3);
        dv[0] = 4'h9;
        run_to(F - 1);
        en[3] = 1'b0;
        run(2 * F);
        run_to(2 * S + 4);
        rst_n = 1'b0;
        run(2);
        rst_n = 1'b1;
        run(2 * F);
        dv[1] = 4'h0; dv[3] = 4'h0; en = 4'hF;
        run(2 * F);
        dv[1] = 4'h1;
        run(2 * F);
        for (int i = 0; i < 40; i++) begin
            en = 4'($urandom);
            for (int j = 0; j < 4; j++) dv[j] = 4'($urandom);
            if ($urandom_range(0, 9) == 0) dv[1] = 4'h0;
            rst_n = ($urandom_range(0, 15) != 0);
            run(1);
            rst_n = 1'b1;
            run($urandom_range(1, 45));
        end
        run(2 * F);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
